// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings, default timing
// constants and the qualification counter width helper.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int unsigned DEF_STABLE_CYCLES = 4096;
  localparam int unsigned DEF_HOLD_CYCLES   = 16;
  localparam int unsigned DEF_CNT_W         = 8;

  // One counter serves both STABLE and HOLD, so size it for the longer of the two.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs; both stages
// reset to 0 so a fresh reset never reports a stale high.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: non-blocking assignments keep this a true two-stage chain; blocking
  // ones would let r_sync see the new r_meta in the same edge and collapse it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_seq.sv
// Reset sequencer behind the PLL: qualifies a continuously stable lock, holds
// system reset for a fixed time, then releases it and counts lock losses in RUN.
module pll_reset_seq
  import pll_rst_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             lock_loss_clr,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned   CW        = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] STABLE_TC = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_TC   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic              w_locked_s;
  logic              w_run_loss;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_sys_rst_n;
  logic              r_ready;
  logic [CNT_W-1:0]  r_loss_cnt;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk_in),
    .rst_n (rst_n),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  // Outputs are written alongside the state transition into or out of RUN, so
  // they always equal (next_state == RUN) registered, with no decode glitches.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end
        end
        STABLE: begin
          if (!w_locked_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_TC) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (!w_locked_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == HOLD_TC) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_sys_rst_n <= 1'b1;
            r_ready     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (!w_locked_s) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
          end
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Only a loss seen while running is counted; losses during qualification are not.
  assign w_run_loss = (r_state == RUN) && !w_locked_s;

  // Clear takes priority, then the same-cycle loss is counted on top of zero.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if (lock_loss_clr) begin
      r_loss_cnt <= w_run_loss ? CNT_W'(1) : '0;
    end else if (w_run_loss && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + CNT_W'(1);
    end
  end

  assign sys_rst_n     = r_sys_rst_n;
  assign ready         = r_ready;
  assign lock_loss_cnt = r_loss_cnt;

endmodule
